// File: rtl/bshifter_pipe_if.sv
// Operand/result handshake bundle for bshifter_pipe.
// The master side feeds operands and drains results; the slave side is the shifter.
interface bshifter_pipe_if #(
    parameter int WIDTH = 32
);
    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] din;
    logic [SHW-1:0]   shift_amt;
    logic             direction;
    logic [1:0]       mode;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] dout;
    logic             carry;
    logic             zero;

    modport master (
        output in_valid, din, shift_amt, direction, mode, out_ready,
        input  in_ready, out_valid, dout, carry, zero
    );

    modport slave (
        input  in_valid, din, shift_amt, direction, mode, out_ready,
        output in_ready, out_valid, dout, carry, zero
    );
endinterface

// File: rtl/bshifter_pipe.sv
// Two-stage pipelined barrel shifter (logical/arithmetic/rotate) with valid/ready backpressure.
// Optional feature macro BSHIFT_BITREV_EN: mode 11 bit-reverses the operand instead of shifting.
module bshifter_pipe #(
    parameter int WIDTH = 32
) (
    input  logic           clk,
    input  logic           rst,
    bshifter_pipe_if.slave bus
);
    localparam int SHW = $clog2(WIDTH);

    logic             s1_valid_r;
    logic [WIDTH-1:0] s1_din_r;
    logic [SHW-1:0]   s1_amt_r;
    logic             s1_dir_r;
    logic [1:0]       s1_mode_r;
    logic             s2_valid_r;
    logic [WIDTH-1:0] dout_r;
    logic             carry_r;

    logic               s2_adv_s;
    logic               s1_adv_s;
    logic [2*WIDTH-1:0] rotl_s;
    logic [2*WIDTH-1:0] rotr_s;
    logic [WIDTH:0]     lext_s;
    logic [WIDTH:0]     rext_s;
    logic [WIDTH-1:0]   asr_s;
    logic [WIDTH-1:0]   res_s;
    logic               carry_s;
    logic               zero_r;

    assign s2_adv_s      = !s2_valid_r || bus.out_ready;
    assign s1_adv_s      = !s1_valid_r || s2_adv_s;
    assign bus.in_ready  = !rst && s1_adv_s;
    assign bus.out_valid = s2_valid_r;
    assign bus.dout      = dout_r;
    assign bus.carry     = carry_r;
    assign bus.zero      = zero_r;

    // Stage 1: capture the operand beat only on an input transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_r <= 1'b0;
            s1_din_r   <= {WIDTH{1'b0}};
            s1_amt_r   <= {SHW{1'b0}};
            s1_dir_r   <= 1'b0;
            s1_mode_r  <= 2'b00;
        end else if (s1_adv_s) begin
            s1_valid_r <= bus.in_valid;
            if (bus.in_valid) begin
                s1_din_r  <= bus.din;
                s1_amt_r  <= bus.shift_amt;
                s1_dir_r  <= bus.direction;
                s1_mode_r <= bus.mode;
            end
        end
    end

    // Shift datapath; the extra bit in lext/rext holds the last bit pushed out.
    always_comb begin
        rotl_s  = {s1_din_r, s1_din_r} << s1_amt_r;
        rotr_s  = {s1_din_r, s1_din_r} >> s1_amt_r;
        lext_s  = {1'b0, s1_din_r} << s1_amt_r;
        rext_s  = {s1_din_r, 1'b0} >> s1_amt_r;
        asr_s   = $signed(s1_din_r) >>> s1_amt_r;
        res_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
        case (s1_mode_r)
            2'b01: begin
                if (s1_dir_r) begin
                    res_s   = asr_s;
                    carry_s = rext_s[0];
                end else begin
                    res_s   = lext_s[WIDTH-1:0];
                    carry_s = lext_s[WIDTH];
                end
            end
            2'b10: begin
                if (s1_dir_r) begin
                    res_s   = rotr_s[WIDTH-1:0];
                    carry_s = (s1_amt_r != {SHW{1'b0}}) && res_s[WIDTH-1];
                end else begin
                    res_s   = rotl_s[2*WIDTH-1:WIDTH];
                    carry_s = (s1_amt_r != {SHW{1'b0}}) && res_s[0];
                end
            end
`ifdef BSHIFT_BITREV_EN
            2'b11: begin
                for (int i = 0; i < WIDTH; i++) begin
                    res_s[i] = s1_din_r[WIDTH-1-i];
                end
                carry_s = 1'b0;
            end
`endif
            default: begin
                if (s1_dir_r) begin
                    res_s   = rext_s[WIDTH:1];
                    carry_s = rext_s[0];
                end else begin
                    res_s   = lext_s[WIDTH-1:0];
                    carry_s = lext_s[WIDTH];
                end
            end
        endcase
    end

    // Stage 2: result register, held while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            dout_r     <= {WIDTH{1'b0}};
            carry_r    <= 1'b0;
            zero_r     <= 1'b0;
        end else if (s2_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                dout_r  <= res_s;
                carry_r <= carry_s;
                zero_r  <= (res_s == {WIDTH{1'b0}});
            end
        end
    end
endmodule

// File: doc/bshifter_pipe.md
Name: bshifter_pipe

Overview:
Parametrised, pipelined successor to the 4-bit combinational barrel shifter. It takes WIDTH-bit operands over a valid/ready handshake and supports left/right logical, arithmetic and rotate modes. It produces result, carry-out and zero flags after a fixed 2-cycle latency, with full backpressure and one operation per cycle. It sits between the ALU operand mux and the writeback/result arbiter.

Parameters:
WIDTH, 32, operand/result width; power of two, 4..64
SHW, $clog2(WIDTH), shift-amount width (derived; do not override)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept operand beat
din  in  WIDTH  operand
shift_amt  in  SHW  shift distance, 0..WIDTH-1
direction  in  1  0 = left, 1 = right
mode  in  2  00 logical, 01 arithmetic, 10 rotate, 11 see Optional Feature
out_valid  out  1  result beat valid
out_ready  in  1  downstream accepts result
dout  out  WIDTH  shifted result
carry  out  1  last bit shifted/rotated across the boundary
zero  out  1  dout == 0

Behaviour:
- Reset:
  - Asserting rst clears both stage valids immediately (asynchronously).
  - dout, carry, zero reset to 0; out_valid resets to 0.
  - in_ready is 0 while rst is high.
  - An in-flight operation is discarded; after rst deasserts, there is no spurious out_valid.
- Handshake:
  - Input transfer when in_valid && in_ready. Output transfer when out_valid && out_ready.
  - While out_valid && !out_ready, dout/carry/zero/out_valid hold stable.
- Pipeline (2 register stages S1, S2):
  - S2 advances when !S2.valid || out_ready.
  - S1 advances when !S1.valid || S2 advances.
  - in_ready = !rst && (!S1.valid || S2 advances). This is a combinational path from out_ready and is accepted.
- Latency and throughput:
  - Latency is exactly 2 cycles from the input transfer edge to out_valid, with no stall.
  - Sustained throughput is 1 op/cycle with out_ready held high.
  - No bubbles are inserted; order is preserved.
- Arithmetic:
  - Logical: vacated bits filled with 0.
  - Arithmetic right: vacated bits filled with din[WIDTH-1]. Arithmetic left is identical to logical left.
  - Rotate: bits leaving one end re-enter the other; amount is taken modulo WIDTH (inherent, since shift_amt < WIDTH).
- carry:
  - Left logical/arith: din[WIDTH-shift_amt]. Right logical/arith: din[shift_amt-1].
  - Rotate left: dout[0]. Rotate right: dout[WIDTH-1].
  - shift_amt == 0: carry = 0 and dout = din in all modes.
- zero: computed from the final dout and registered with it.
- Simultaneous events: input accept and output drain in the same cycle with a full pipeline is legal and loses no beat.
- Operand capture: din, shift_amt, direction and mode are sampled only on the input transfer. Changes while in_ready is low are ignored.

Optional Feature:
BSHIFT_BITREV_EN
- Defined: mode 11 produces the bit-reversed din (dout[i] = din[WIDTH-1-i]). shift_amt and direction are ignored; carry = 0; latency is unchanged.
- Undefined: mode 11 behaves exactly as mode 00 (logical).

Test Plan:
- WIDTH=8, din=0x96, amt=3, dir=0, mode=00, out_ready=1 -> 2 cycles later dout=0xB0, carry=0 (din[5]=0), zero=0.
- din=0x96, amt=2, dir=1, mode=01 -> dout=0xE5, carry=1 (din[1]); then mode=10 dir=1 amt=2 -> dout=0xA5, carry=1 (dout[7]).
- din=0x80, amt=7, dir=1, mode=00 -> dout=0x01; din=0x01, amt=1, dir=1, mode=00 -> dout=0x00, zero=1, carry=1.
- Back-to-back 10 ops with out_ready=1 -> 10 consecutive out_valid beats, in order. Then hold out_ready=0 for 5 cycles with in_valid=1 -> exactly 2 ops accepted, in_ready low, dout stable until out_ready returns.
- Assert rst mid-stream with 2 ops in flight -> out_valid=0, dout=0 immediately. After release, first new op emerges 2 cycles after its accept; no stale beat appears.
- mode=11, din=0x96: with BSHIFT_BITREV_EN -> dout=0x69, carry=0; without -> dout equals the logical shift result for the given amt/dir.
